// File: rtl/vt_pkg.sv
// Shared VT52 terminal constants: flow-control ASCII bytes and the transmit FSM encoding.
package vt_pkg;
   localparam logic [7:0] XON  = 8'h11;
   localparam logic [7:0] XOFF = 8'h13;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_e;
endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with registered occupancy.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   fill
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] fill_q;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop frees the slot the write lands in, so a full FIFO still accepts alongside a pop.
   assign do_push = push && (!full || do_pop);
   assign fill    = fill_q;
   // Stale storage is masked so an empty FIFO always presents zero.
   assign dout    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ONE;
         if (do_pop)  rd_ptr <= rd_ptr + ONE;
         case ({do_push, do_pop})
            2'b10:   fill_q <= fill_q + ONE;
            2'b01:   fill_q <= fill_q - ONE;
            default: fill_q <= fill_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/rx_flow_fifo.sv
// UART receive buffer for the VT52 decoder; also arbitrates the UART transmit port
// between automatic XON/XOFF flow bytes and keyboard characters.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | transmitter free; may launch a flow byte or keyboard byte
//  WAIT_BUSY | byte launched; waiting for tx_done to drop
//  WAIT_DONE | transmitter busy; waiting for tx_done to return high
module rx_flow_fifo
   import vt_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int HI_MARK = 12,
   parameter int LO_MARK = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     rx_done,
   input  logic [7:0]               rx_data,
   output logic                     char_valid,
   output logic [7:0]               char_data,
   input  logic                     char_ready,
   input  logic                     kbd_send,
   input  logic [6:0]               kbd_char,
   output logic [7:0]               tx_data,
   output logic                     tx_send,
   input  logic                     tx_done,
   output logic                     xoff_sent,
   output logic                     overrun,
   output logic                     kbd_drop,
   output logic [$clog2(DEPTH):0]   fill
);
   localparam int FW = $clog2(DEPTH) + 1;
   localparam logic [FW-1:0] HI_F = FW'(HI_MARK);
   localparam logic [FW-1:0] LO_F = FW'(LO_MARK);

   logic       rx_done_q;
   logic       push_edge;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic       xoff_pend;
   logic       xon_pend;
   logic       flow_pend;
   logic [7:0] flow_byte;
   logic       kbd_full;
   logic [7:0] kbd_hold;
   logic [7:0] tx_data_q;
   logic       send_flow;
   logic       send_kbd;
   tx_state_e  state;
   tx_state_e  state_nx;

   assign push_edge  = rx_done && !rx_done_q;
   assign char_valid = !fifo_empty;
   assign pop        = char_valid && char_ready;

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_edge),
      .pop     (pop),
      .din     (rx_data),
      .dout    (char_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .fill    (fill)
   );

   // Flow requests are re-derived every cycle and never latched.
   assign xoff_pend = (fill >= HI_F) && !xoff_sent;
   assign xon_pend  = (fill <= LO_F) && xoff_sent;
   assign flow_pend = xoff_pend || xon_pend;
   assign flow_byte = xoff_pend ? XOFF : XON;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_done_q <= 1'b0;
         overrun   <= 1'b0;
         kbd_full  <= 1'b0;
         kbd_hold  <= 8'h00;
         kbd_drop  <= 1'b0;
         xoff_sent <= 1'b0;
         tx_data_q <= 8'h00;
      end else begin
         rx_done_q <= rx_done;
         if (push_edge && fifo_full && !pop) overrun <= 1'b1;
         if (kbd_send && !kbd_full) begin
            kbd_full <= 1'b1;
            kbd_hold <= {1'b0, kbd_char};
         end else if (send_kbd) begin
            kbd_full <= 1'b0;
         end
         if (kbd_send && kbd_full) kbd_drop <= 1'b1;
         if (send_flow) xoff_sent <= !xoff_sent;
         tx_data_q <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (tx_done && (flow_pend || kbd_full)) state_nx = WAIT_BUSY;
         WAIT_BUSY: if (!tx_done) state_nx = WAIT_DONE;
         WAIT_DONE: if (tx_done) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Launch outputs are combinational so a byte leaves in the cycle IDLE sees it.
   always_comb begin
      send_flow = 1'b0;
      send_kbd  = 1'b0;
      tx_data   = tx_data_q;
      if (state == IDLE && tx_done) begin
         if (flow_pend) begin
            send_flow = 1'b1;
            tx_data   = flow_byte;
         end else if (kbd_full) begin
            send_kbd  = 1'b1;
            tx_data   = kbd_hold;
         end
      end
      tx_send = send_flow || send_kbd;
   end
endmodule

// File: tb/tb_rx_flow_fifo.sv
// Randomised bench for rx_flow_fifo: queue-based reference model plus receive/transmit scoreboards.
module tb_rx_flow_fifo;
   localparam int DEPTH = 16;
   localparam int HI    = 12;
   localparam int LO    = 4;

   logic       clk        = 1'b0;
   logic       reset_n    = 1'b0;
   logic       rx_done    = 1'b0;
   logic [7:0] rx_data    = 8'h00;
   logic       char_ready = 1'b0;
   logic       kbd_send   = 1'b0;
   logic [6:0] kbd_char   = 7'h00;
   logic       tx_done    = 1'b1;
   logic       char_valid, tx_send, xoff_sent, overrun, kbd_drop;
   logic [7:0] char_data, tx_data;
   logic [4:0] fill;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] rx_q[$];
   logic [7:0] tx_exp[$];
   bit         m_rx_prev, m_xs, m_ovr, m_kdrop, m_kfull;
   logic [7:0] m_kbyte, m_txlast;
   int         m_phase;
   bit         uart_start = 1'b0;
   bit         uart_stall = 1'b0;

   always #5 clk = ~clk;

   rx_flow_fifo #(.DEPTH(DEPTH), .HI_MARK(HI), .LO_MARK(LO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx_done    (rx_done),
      .rx_data    (rx_data),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .kbd_send   (kbd_send),
      .kbd_char   (kbd_char),
      .tx_data    (tx_data),
      .tx_send    (tx_send),
      .tx_done    (tx_done),
      .xoff_sent  (xoff_sent),
      .overrun    (overrun),
      .kbd_drop   (kbd_drop),
      .fill       (fill)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_fill"}, fill, 0);
      chk({tag, "_char_valid"}, char_valid, 0);
      chk({tag, "_char_data"}, char_data, 0);
      chk({tag, "_tx_data"}, tx_data, 0);
      chk({tag, "_tx_send"}, tx_send, 0);
      chk({tag, "_xoff_sent"}, xoff_sent, 0);
      chk({tag, "_overrun"}, overrun, 0);
      chk({tag, "_kbd_drop"}, kbd_drop, 0);
   endtask

   // Reference model and scoreboards, evaluated mid-cycle with inputs stable.
   always @(negedge clk) begin
      int         sz;
      bit         flow_p, send, kbd_out, push;
      logic [7:0] fb, sent;
      if (!reset_n) begin
         rx_q.delete();
         tx_exp.delete();
         m_rx_prev = 0; m_xs = 0; m_ovr = 0; m_kdrop = 0; m_kfull = 0;
         m_kbyte = 0; m_txlast = 0; m_phase = 0;
         chk_reset_outputs("in_reset");
      end else begin
         sz = rx_q.size();
         chk("fill", fill, sz);
         chk("char_valid", char_valid, sz > 0);
         chk("xoff_sent", xoff_sent, m_xs);
         chk("overrun", overrun, m_ovr);
         chk("kbd_drop", kbd_drop, m_kdrop);

         flow_p  = (sz >= HI && !m_xs) || (sz <= LO && m_xs);
         fb      = m_xs ? 8'h11 : 8'h13;
         send    = (m_phase == 0) && tx_done && (flow_p || m_kfull);
         kbd_out = send && !flow_p;
         if (send) begin
            sent = flow_p ? fb : m_kbyte;
            tx_exp.push_back(sent);
            m_txlast = sent;
         end
         chk("tx_send", tx_send, send);

         if (tx_send) begin
            uart_start = 1;
            if (tx_exp.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL tx_byte: got %0h expected none at %0t", tx_data, $time);
            end else chk("tx_byte", tx_data, tx_exp.pop_front());
         end else chk("tx_hold", tx_data, m_txlast);

         if (char_valid && char_ready) begin
            if (sz == 0) begin
               n_tests++; n_fail++;
               $display("FAIL rx_byte: got %0h expected none at %0t", char_data, $time);
            end else chk("rx_byte", char_data, rx_q[0]);
         end

         push = rx_done && !m_rx_prev;
         if (sz > 0 && char_ready) void'(rx_q.pop_front());
         if (push) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(rx_data);
            else m_ovr = 1;
         end
         m_rx_prev = rx_done;

         if (kbd_send && m_kfull) m_kdrop = 1;
         if (kbd_send && !m_kfull) begin
            m_kfull = 1;
            m_kbyte = {1'b0, kbd_char};
         end else if (kbd_out) m_kfull = 0;
         if (send && flow_p) m_xs = !m_xs;

         case (m_phase)
            0: if (send) m_phase = 1;
            1: if (!tx_done) m_phase = 2;
            default: if (tx_done) m_phase = 0;
         endcase
      end
   end

   // UART transmitter: after a launch, tx_done stays high a little, drops for a while, then recovers.
   initial begin
      int hi_wait, lo_len;
      bit busy;
      hi_wait = 0; lo_len = 0; busy = 0;
      forever begin
         @(posedge clk); #1;
         if (uart_start) begin
            uart_start = 0;
            hi_wait = $urandom_range(0, 2);
            lo_len  = $urandom_range(1, 4);
            busy    = 1;
         end
         if (uart_stall) tx_done = 0;
         else if (busy) begin
            if (hi_wait > 0) begin hi_wait--; tx_done = 1; end
            else if (lo_len > 0) begin lo_len--; tx_done = 0; end
            else begin tx_done = 1; busy = 0; end
         end else tx_done = 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_data = b; rx_done = 1; tick(1);
      rx_done = 0; tick(1);
   endtask

   initial begin
      tick(3);
      chk_reset_outputs("reset");
      reset_n = 1;
      tick(2);

      // Capture then drain three bytes.
      push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
      chk("cap_fill", fill, 3);
      chk("cap_head", char_data, 8'h41);
      char_ready = 1; tick(3); char_ready = 0;
      chk("cap_empty", char_valid, 0);

      // Overrun with 17 pushes; XOFF goes out on the way up, XON on the way down.
      for (int i = 1; i <= 17; i++) push_byte(8'(i));
      chk("ovr_fill", fill, 16);
      chk("ovr_flag", overrun, 1);
      chk("ovr_head", char_data, 8'h01);
      chk("ovr_xoff", xoff_sent, 1);
      char_ready = 1; tick(40); char_ready = 0;
      chk("ovr_xon", xoff_sent, 0);
      chk("ovr_drained", fill, 0);

      // Keyboard request in the cycle XOFF becomes pending.
      tick(10);
      for (int i = 0; i < 11; i++) push_byte(8'h20 + 8'(i));
      rx_data = 8'h2b; rx_done = 1; tick(1);
      rx_done = 0; kbd_send = 1; kbd_char = 7'h61; tick(1);
      kbd_send = 0; tick(12);
      chk("arb_xoff", xoff_sent, 1);
      char_ready = 1; tick(40); char_ready = 0;

      // Second keyboard char dropped while the transmitter is stalled.
      uart_stall = 1; tick(2);
      kbd_send = 1; kbd_char = 7'h78; tick(1);
      kbd_send = 0; tick(1);
      kbd_send = 1; kbd_char = 7'h79; tick(1);
      kbd_send = 0; tick(1);
      chk("kbd_drop_flag", kbd_drop, 1);
      uart_stall = 0; tick(12);

      // Asynchronous reset with five bytes buffered and a transmit in flight.
      for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
      kbd_send = 1; kbd_char = 7'h7a; tick(1);
      kbd_send = 0; tick(3);
      #2 reset_n = 0;
      #1 chk_reset_outputs("async");
      tick(2);
      reset_n = 1; tick(1);
      push_byte(8'h55);
      chk("post_reset_fill", fill, 1);
      chk("post_reset_head", char_data, 8'h55);
      char_ready = 1; tick(2); char_ready = 0;

      // Randomised traffic with alternating drain rates and rare resets.
      for (int blk = 0; blk < 16; blk++) begin
         int rdy_pct;
         rdy_pct = (blk % 2 == 0) ? 20 : 85;
         for (int c = 0; c < 200; c++) begin
            rx_done    = 1'($urandom_range(0, 1));
            rx_data    = 8'($urandom);
            char_ready = ($urandom_range(0, 99) < rdy_pct);
            kbd_send   = ($urandom_range(0, 11) == 0);
            kbd_char   = 7'($urandom);
            if ($urandom_range(0, 999) == 0) reset_n = 0;
            tick(1);
            reset_n = 1;
         end
      end
      rx_done = 0; kbd_send = 0; char_ready = 1;
      tick(60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
